// File: rtl/writeback_scoreboard_if.sv
// Bundle of the issue, result and register-file-write signals around the writeback scoreboard.
// The master side drives decode/execute inputs; the slave side is the scoreboard itself.
interface writeback_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int NREG = 1 << ADDR_W;

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_dst;
  logic [ADDR_W-1:0] src_a;
  logic [ADDR_W-1:0] src_b;
  logic              stall;
  logic              res_valid;
  logic              res_ready;
  logic              res_wen;
  logic [ADDR_W-1:0] res_dst;
  logic [DATA_W-1:0] res_data;
  logic              wb_hold;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NREG-1:0]   busy;
  logic              sb_err;

  modport master (
    output issue_valid, issue_dst, src_a, src_b,
    output res_valid, res_wen, res_dst, res_data, wb_hold,
    input  stall, res_ready, wr_en, wr_addr, wr_data, busy, sb_err
  );

  modport slave (
    input  issue_valid, issue_dst, src_a, src_b,
    input  res_valid, res_wen, res_dst, res_data, wb_hold,
    output stall, res_ready, wr_en, wr_addr, wr_data, busy, sb_err
  );
endinterface

// File: rtl/writeback_scoreboard.sv
// Writeback holding register feeding the register file port, plus per-register
// pending-write counters that stall decode on read-after-write hazards.
module writeback_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PEND_W = 2
) (
  input  logic                  elk,
  input  logic                  nrst,
  writeback_scoreboard_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic              full_q,   full_d;
  logic              q_wen_q,  q_wen_d;
  logic [ADDR_W-1:0] q_dst_q,  q_dst_d;
  logic [DATA_W-1:0] q_data_q, q_data_d;
  logic              sb_err_q, sb_err_d;
  logic [PEND_W-1:0] cnt_q [NREG];
  logic [PEND_W-1:0] cnt_d [NREG];

  logic            accept;
  logic            retire;
  logic            issue;
  logic            stall;
  logic [NREG-1:0] busy;

  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++) begin
      busy[r] = |cnt_q[r];
    end
  end

  // A full counter blocks further issues to that register so it can never wrap.
  assign stall  = busy[bus.src_a] | busy[bus.src_b] |
                  (bus.issue_valid && (cnt_q[bus.issue_dst] == CNT_MAX));
  assign issue  = bus.issue_valid && !stall && (bus.issue_dst != '0);
  assign retire = full_q && !bus.wb_hold && q_wen_q && (q_dst_q != '0);
  assign accept = bus.res_valid && (!full_q || !bus.wb_hold);

  assign bus.stall     = stall;
  assign bus.busy      = busy;
  assign bus.res_ready = !full_q || !bus.wb_hold;
  assign bus.wr_en     = retire;
  assign bus.wr_addr   = full_q ? q_dst_q  : '0;
  assign bus.wr_data   = full_q ? q_data_q : '0;
  assign bus.sb_err    = sb_err_q;

  always_comb begin
    full_d   = full_q;
    q_wen_d  = q_wen_q;
    q_dst_d  = q_dst_q;
    q_data_d = q_data_q;
    if (accept) begin
      full_d   = 1'b1;
      q_wen_d  = bus.res_wen;
      q_dst_d  = bus.res_dst;
      q_data_d = bus.res_data;
    end else if (full_q && !bus.wb_hold) begin
      full_d = 1'b0;
    end
  end

  // Issue and retire to the same register on one edge cancel out.
  always_comb begin
    sb_err_d = sb_err_q;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (issue && (bus.issue_dst == ADDR_W'(r)) &&
          !(retire && (q_dst_q == ADDR_W'(r)))) begin
        cnt_d[r] = cnt_q[r] + PEND_W'(1);
      end else if (retire && (q_dst_q == ADDR_W'(r)) &&
                   !(issue && (bus.issue_dst == ADDR_W'(r)))) begin
        if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - PEND_W'(1);
        end else begin
          sb_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge elk or posedge nrst) begin
    if (nrst) begin
      full_q   <= 1'b0;
      q_wen_q  <= 1'b0;
      q_dst_q  <= '0;
      q_data_q <= '0;
      sb_err_q <= 1'b0;
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      full_q   <= full_d;
      q_wen_q  <= q_wen_d;
      q_dst_q  <= q_dst_d;
      q_data_q <= q_data_d;
      sb_err_q <= sb_err_d;
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end
endmodule

// File: tb/tb_writeback_scoreboard.sv
// Self-checking bench for writeback_scoreboard: directed scenarios plus a randomized
// run compared against a queue-free behavioural model of counts and the holding entry.
module tb_writeback_scoreboard;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PEND_W = 2;
  localparam int NREG   = 1 << ADDR_W;
  localparam int MAXC   = (1 << PEND_W) - 1;

  logic elk = 1'b0;
  logic nrst = 1'b1;
  always #5 elk = ~elk;

  writeback_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  writeback_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PEND_W(PEND_W)) dut (
    .elk (elk),
    .nrst(nrst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int          m_cnt [NREG];
  bit          m_full, m_wen, m_err;
  int          m_dst;
  logic [31:0] m_data;

  function automatic bit m_busy(int r);
    return (r != 0) && (m_cnt[r] != 0);
  endfunction

  function automatic logic [NREG-1:0] m_busy_vec();
    logic [NREG-1:0] v;
    for (int r = 0; r < NREG; r++) v[r] = m_busy(r);
    return v;
  endfunction

  function automatic bit m_stall();
    return m_busy(int'(bus.src_a)) || m_busy(int'(bus.src_b)) ||
           (bus.issue_valid && (m_cnt[int'(bus.issue_dst)] == MAXC));
  endfunction

  function automatic bit m_wr_en();
    return m_full && !bus.wb_hold && m_wen && (m_dst != 0);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
    m_full = 0; m_wen = 0; m_err = 0; m_dst = 0; m_data = '0;
  endtask

  task automatic drive_idle();
    bus.issue_valid = 0; bus.issue_dst = '0; bus.src_a = '0; bus.src_b = '0;
    bus.res_valid = 0; bus.res_wen = 0; bus.res_dst = '0; bus.res_data = '0;
    bus.wb_hold = 0;
  endtask

  // One clock: evaluate the model's events from inputs held before the edge, then apply them.
  task automatic tick();
    bit acc, ret, iss, hold, rw;
    int idst, rd;
    logic [31:0] rdat;
    acc  = bus.res_valid && (!m_full || !bus.wb_hold);
    ret  = m_wr_en();
    iss  = bus.issue_valid && !m_stall() && (bus.issue_dst != 0);
    idst = int'(bus.issue_dst);
    hold = bus.wb_hold;
    rw   = bus.res_wen;
    rd   = int'(bus.res_dst);
    rdat = bus.res_data;
    @(posedge elk);
    if (iss) m_cnt[idst]++;
    if (ret) begin
      if (m_cnt[m_dst] == 0) m_err = 1;
      else m_cnt[m_dst]--;
    end
    if (acc) begin
      m_full = 1; m_wen = rw; m_dst = rd; m_data = rdat;
    end else if (m_full && !hold) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    nrst = 1;
    #2;
    nrst = 0;
    model_clear();
  endtask

  task automatic test_reset();
    bus.issue_valid = 1; bus.issue_dst = 5'd4;
    bus.res_valid = 1; bus.res_wen = 1; bus.res_dst = 5'd8; bus.res_data = 32'h1234_5678;
    tick();
    bus.issue_valid = 0;
    bus.res_dst = 5'd4; bus.res_data = 32'hCAFE_0004;
    tick();
    bus.res_valid = 0;
    #1;
    n_tests++; if (bus.sb_err !== 1'b1) begin n_fail++; $display("FAIL t1_err_pre got=%0b exp=1", bus.sb_err); end
    n_tests++; if (bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL t1_wr_en_pre got=%0b exp=1", bus.wr_en); end
    n_tests++; if (bus.busy[4] !== 1'b1) begin n_fail++; $display("FAIL t1_busy4_pre got=%0b exp=1", bus.busy[4]); end
    nrst = 1;
    #1;
    n_tests++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL t1_wr_en got=%0b exp=0", bus.wr_en); end
    n_tests++; if (bus.busy !== '0) begin n_fail++; $display("FAIL t1_busy got=%h exp=0", bus.busy); end
    n_tests++; if (bus.res_ready !== 1'b1) begin n_fail++; $display("FAIL t1_ready got=%0b exp=1", bus.res_ready); end
    n_tests++; if (bus.sb_err !== 1'b0) begin n_fail++; $display("FAIL t1_err got=%0b exp=0", bus.sb_err); end
    n_tests++; if (bus.wr_addr !== '0) begin n_fail++; $display("FAIL t1_wr_addr got=%0d exp=0", bus.wr_addr); end
    #1;
    nrst = 0;
    model_clear();
    tick();
    n_tests++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL t1_dropped got=%0b exp=0", bus.wr_en); end
  endtask

  task automatic test_basic();
    do_reset();
    bus.issue_valid = 1; bus.issue_dst = 5'd5;
    #1;
    n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL t2_stall got=%0b exp=0", bus.stall); end
    tick();
    bus.issue_valid = 0;
    bus.res_valid = 1; bus.res_wen = 1; bus.res_dst = 5'd5; bus.res_data = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (bus.busy[5] !== 1'b1) begin n_fail++; $display("FAIL t2_busy5_set got=%0b exp=1", bus.busy[5]); end
    n_tests++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL t2_wr_en_early got=%0b exp=0", bus.wr_en); end
    tick();
    bus.res_valid = 0;
    #1;
    n_tests++; if (bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL t2_wr_en got=%0b exp=1", bus.wr_en); end
    n_tests++; if (bus.wr_addr !== 5'd5) begin n_fail++; $display("FAIL t2_wr_addr got=%0d exp=5", bus.wr_addr); end
    n_tests++; if (bus.wr_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL t2_wr_data got=%h exp=deadbeef", bus.wr_data); end
    tick();
    n_tests++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL t2_wr_en_once got=%0b exp=0", bus.wr_en); end
    n_tests++; if (bus.busy[5] !== 1'b0) begin n_fail++; $display("FAIL t2_busy5_clr got=%0b exp=0", bus.busy[5]); end
  endtask

  task automatic test_hazard();
    do_reset();
    bus.issue_valid = 1; bus.issue_dst = 5'd9;
    tick();
    bus.issue_valid = 0; bus.src_a = 5'd9;
    #1;
    n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL t3_stall_set got=%0b exp=1", bus.stall); end
    bus.res_valid = 1; bus.res_wen = 1; bus.res_dst = 5'd9; bus.res_data = 32'h0000_0009;
    tick();
    bus.res_valid = 0;
    #1;
    n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL t3_stall_hold got=%0b exp=1", bus.stall); end
    tick();
    n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL t3_stall_clr got=%0b exp=0", bus.stall); end
    bus.src_a = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.issue_valid = 1; bus.issue_dst = 5'd6;
    tick();
    bus.issue_valid = 0;
    bus.wb_hold = 1;
    bus.res_valid = 1; bus.res_wen = 1; bus.res_dst = 5'd6; bus.res_data = 32'hA5A5_A5A5;
    tick();
    bus.res_valid = 0;
    #1;
    n_tests++; if (bus.res_ready !== 1'b0) begin n_fail++; $display("FAIL t4_ready_held got=%0b exp=0", bus.res_ready); end
    n_tests++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL t4_wr_en_held got=%0b exp=0", bus.wr_en); end
    tick();
    tick();
    bus.res_valid = 1; bus.res_dst = 5'd6; bus.res_data = 32'h1111_1111;
    #1;
    n_tests++; if (bus.busy[6] !== 1'b1) begin n_fail++; $display("FAIL t4_busy6 got=%0b exp=1", bus.busy[6]); end
    tick();
    bus.res_valid = 0; bus.wb_hold = 0;
    #1;
    n_tests++; if (bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL t4_wr_en got=%0b exp=1", bus.wr_en); end
    n_tests++; if (bus.wr_data !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL t4_entry_kept got=%h exp=a5a5a5a5", bus.wr_data); end
    n_tests++; if (bus.res_ready !== 1'b1) begin n_fail++; $display("FAIL t4_ready got=%0b exp=1", bus.res_ready); end
    tick();
    n_tests++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL t4_wr_en_done got=%0b exp=0", bus.wr_en); end
    n_tests++; if (bus.busy[6] !== 1'b0) begin n_fail++; $display("FAIL t4_busy6_clr got=%0b exp=0", bus.busy[6]); end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.issue_valid = 1; bus.issue_dst = 5'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL t5_issue%0d_stall got=%0b exp=0", i, bus.stall); end
      tick();
    end
    #1;
    n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL t5_full_stall got=%0b exp=1", bus.stall); end
    tick();
    bus.issue_valid = 0;
    bus.res_valid = 1; bus.res_wen = 1; bus.res_dst = 5'd3; bus.res_data = 32'h3;
    tick();
    bus.res_valid = 0;
    tick();
    bus.issue_valid = 1;
    #1;
    n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL t5_after_retire got=%0b exp=0", bus.stall); end
    tick();
    #1;
    n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL t5_refull got=%0b exp=1", bus.stall); end
    bus.issue_valid = 0;
    for (int k = 0; k < 3; k++) begin
      bus.res_valid = 1;
      tick();
      bus.res_valid = 0;
      tick();
      n_tests++; if (bus.busy[3] !== (k < 2)) begin n_fail++; $display("FAIL t5_drain%0d got=%0b exp=%0b", k, bus.busy[3], k < 2); end
    end
    n_tests++; if (bus.sb_err !== 1'b0) begin n_fail++; $display("FAIL t5_err got=%0b exp=0", bus.sb_err); end
  endtask

  task automatic test_r0_err();
    do_reset();
    bus.res_valid = 1; bus.res_wen = 1; bus.res_dst = 5'd0; bus.res_data = 32'hFFFF_0000;
    tick();
    bus.res_valid = 0;
    #1;
    n_tests++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL t6_r0_wr_en got=%0b exp=0", bus.wr_en); end
    bus.res_valid = 1; bus.res_wen = 0; bus.res_dst = 5'd4;
    tick();
    bus.res_valid = 0;
    #1;
    n_tests++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL t6_nowen_wr_en got=%0b exp=0", bus.wr_en); end
    tick();
    n_tests++; if (bus.sb_err !== 1'b0) begin n_fail++; $display("FAIL t6_no_err got=%0b exp=0", bus.sb_err); end
    bus.res_valid = 1; bus.res_wen = 1; bus.res_dst = 5'd7; bus.res_data = 32'h7777_0007;
    tick();
    bus.res_valid = 0;
    #1;
    n_tests++; if (bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL t6_r7_wr_en got=%0b exp=1", bus.wr_en); end
    n_tests++; if (bus.wr_addr !== 5'd7) begin n_fail++; $display("FAIL t6_r7_addr got=%0d exp=7", bus.wr_addr); end
    tick();
    n_tests++; if (bus.sb_err !== 1'b1) begin n_fail++; $display("FAIL t6_err_set got=%0b exp=1", bus.sb_err); end
    n_tests++; if (bus.busy[7] !== 1'b0) begin n_fail++; $display("FAIL t6_busy7 got=%0b exp=0", bus.busy[7]); end
  endtask

  task automatic test_random();
    int pend [$];
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.issue_valid = ($urandom % 3) != 0;
      bus.issue_dst   = ADDR_W'($urandom % 8);
      bus.src_a       = ($urandom % 2) ? ADDR_W'($urandom % 8) : '0;
      bus.src_b       = ($urandom % 3) == 0 ? ADDR_W'($urandom % 8) : '0;
      bus.wb_hold     = ($urandom % 4) == 0;
      bus.res_valid   = $urandom % 2;
      bus.res_wen     = ($urandom % 8) != 0;
      bus.res_data    = $urandom;
      pend.delete();
      for (int r = 1; r < 8; r++) if (m_cnt[r] != 0) pend.push_back(r);
      if (pend.size() != 0 && ($urandom % 10) != 0)
        bus.res_dst = ADDR_W'(pend[$urandom % pend.size()]);
      else
        bus.res_dst = ADDR_W'($urandom % 8);
      #1;
      n_tests++; if (bus.stall !== m_stall()) begin n_fail++; $display("FAIL rnd_stall c=%0d got=%0b exp=%0b", c, bus.stall, m_stall()); end
      n_tests++; if (bus.res_ready !== (!m_full || !bus.wb_hold)) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, bus.res_ready, !m_full || !bus.wb_hold); end
      n_tests++; if (bus.wr_en !== m_wr_en()) begin n_fail++; $display("FAIL rnd_wr_en c=%0d got=%0b exp=%0b", c, bus.wr_en, m_wr_en()); end
      n_tests++; if (bus.wr_addr !== (m_full ? ADDR_W'(m_dst) : '0)) begin n_fail++; $display("FAIL rnd_wr_addr c=%0d got=%0d exp=%0d", c, bus.wr_addr, m_full ? m_dst : 0); end
      n_tests++; if (bus.wr_data !== (m_full ? m_data : 32'h0)) begin n_fail++; $display("FAIL rnd_wr_data c=%0d got=%h exp=%h", c, bus.wr_data, m_full ? m_data : 32'h0); end
      n_tests++; if (bus.busy !== m_busy_vec()) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%h exp=%h", c, bus.busy, m_busy_vec()); end
      n_tests++; if (bus.sb_err !== m_err) begin n_fail++; $display("FAIL rnd_err c=%0d got=%0b exp=%0b", c, bus.sb_err, m_err); end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    model_clear();
    nrst = 1;
    repeat (2) @(posedge elk);
    #1;
    nrst = 0;
    test_reset();
    test_basic();
    test_hazard();
    test_backpressure();
    test_saturation();
    test_r0_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
